// File: rtl/nf_seven_seg_dynamic.sv
// Time-multiplexed seven-segment driver: frame-aligned shadow registers, one-hot digit scan, CC/CA polarity.
// Optional leading-zero blanking is compiled in with `define NF_SEVEN_SEG_LZB_EN.
module nf_seven_seg_dynamic #(
  parameter int hn       = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [hn*4-1:0] hex,
  input  logic [hn-1:0]   dp,
  input  logic          upd,
  input  logic          cc_ca,
  input  logic          blank_en,
  output logic [7:0]    seg,
  output logic [hn-1:0] dig_sel,
  output logic          frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (hn > 1) ? $clog2(hn) : 1;

  logic [PW-1:0]   pres;
  logic [IW-1:0]   idx;
  logic            pend;
  logic [hn*4-1:0] hex_pend, hex_disp;
  logic [hn-1:0]   dp_pend, dp_disp;

  logic            tick;
  logic            boundary;
  logic [3:0]      nib;
  logic [6:0]      glyph;
  logic [7:0]      seg_on;
  logic [hn-1:0]   onehot;
  logic [7:0]      seg_nxt;
  logic [hn-1:0]   dig_nxt;

  assign tick     = (pres == PW'(SCAN_DIV - 1));
  assign boundary = tick && (idx == IW'(hn - 1));

  always_comb begin
    nib    = hex_disp[{idx, 2'b00} +: 4];
    glyph  = 7'h00;
    onehot = '0;
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
`ifdef NF_SEVEN_SEG_LZB_EN
    // Current digit and everything above it zero -> leading zero; digit 0 always shows.
    if (blank_en && (idx != '0) && ((hex_disp >> {idx, 2'b00}) == '0))
      glyph = 7'h00;
`endif
    seg_on = {dp_disp[idx], glyph};
    for (int unsigned i = 0; i < hn; i++)
      onehot[i] = (idx == IW'(i));
    seg_nxt = cc_ca ? ~seg_on : seg_on;
    dig_nxt = cc_ca ? onehot : ~onehot;
  end

`ifndef NF_SEVEN_SEG_LZB_EN
  logic unused_blank_en;
  assign unused_blank_en = blank_en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pres       <= '0;
      idx        <= '0;
      pend       <= 1'b0;
      hex_pend   <= '0;
      dp_pend    <= '0;
      hex_disp   <= '0;
      dp_disp    <= '0;
      frame_done <= 1'b0;
      seg        <= cc_ca ? 8'hFF : 8'h00;
      dig_sel    <= cc_ca ? '0 : '1;
    end else begin
      pres <= tick ? '0 : pres + 1'b1;
      if (tick)
        idx <= (idx == IW'(hn - 1)) ? '0 : idx + 1'b1;

      // An update landing on the boundary bypasses the pending stage.
      if (boundary && upd) begin
        hex_disp <= hex;
        dp_disp  <= dp;
        pend     <= 1'b0;
      end else if (boundary && pend) begin
        hex_disp <= hex_pend;
        dp_disp  <= dp_pend;
        pend     <= 1'b0;
      end else if (upd) begin
        hex_pend <= hex;
        dp_pend  <= dp;
        pend     <= 1'b1;
      end

      seg        <= seg_nxt;
      dig_sel    <= dig_nxt;
      frame_done <= boundary;
    end
  end

endmodule
